// File: rtl/pov_column_reader.sv
// POV frame-buffer column reader: fetches one column per col_tick into a credit-limited skid FIFO.
// Define POV_RD_MIRROR_EN to read columns in reverse order for counter-rotating mounts.
module pov_column_reader #(
    parameter int DAT_WIDTH    = 24,
    parameter int ADDR_WIDTH   = 14,
    parameter int LEDS_PER_COL = 64,
    parameter int NUM_COLS     = 256,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        index_pulse,
    input  logic                        col_tick,
    output logic [ADDR_WIDTH-1:0]       rdaddress,
    input  logic [DAT_WIDTH-1:0]        q,
    output logic [DAT_WIDTH-1:0]        pix_data,
    output logic                        pix_valid,
    input  logic                        pix_ready,
    output logic                        pix_sop,
    output logic                        pix_eop,
    output logic [$clog2(NUM_COLS)-1:0] col_num,
    output logic                        overrun
);

    localparam int CW = $clog2(NUM_COLS);
    localparam int LW = $clog2(LEDS_PER_COL);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] ST_SYNC  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_FETCH = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [CW-1:0] COL_LAST = CW'(NUM_COLS - 1);
    localparam logic [LW-1:0] LED_LAST = LW'(LEDS_PER_COL - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [LW-1:0] led_q, led_d;
    logic          ovr_q, ovr_d;

    logic v1_q, v1_d, v2_q, v2_d;
    logic s1_sop_q, s1_sop_d, s1_eop_q, s1_eop_d;
    logic s2_sop_q, s2_sop_d, s2_eop_q, s2_eop_d;

    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]        cnt_q, cnt_d;
    logic [DAT_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [DAT_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
    logic                 fifo_sop_q  [FIFO_DEPTH];
    logic                 fifo_sop_d  [FIFO_DEPTH];
    logic                 fifo_eop_q  [FIFO_DEPTH];
    logic                 fifo_eop_d  [FIFO_DEPTH];

    logic          issue, push, pop, abort, credit;
    logic [NW:0]   occ;
    logic [CW-1:0] col_addr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
`ifdef POV_RD_MIRROR_EN
        col_addr = COL_LAST - col_q;
`else
        col_addr = col_q;
`endif
        rdaddress = ADDR_WIDTH'({col_addr, led_q});
    end

    // Reads already in flight hold a FIFO slot so returning data always fits.
    always_comb begin
        occ    = (NW+1)'(cnt_q) + (NW+1)'(v1_q) + (NW+1)'(v2_q);
        credit = occ < (NW+1)'(FIFO_DEPTH);
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        led_d   = led_q;
        ovr_d   = ovr_q;
        issue   = 1'b0;
        abort   = index_pulse && (state_q != ST_SYNC);
        case (state_q)
            ST_SYNC: begin
                if (index_pulse) begin
                    state_d = ST_IDLE;
                    col_d   = '0;
                    led_d   = '0;
                    ovr_d   = 1'b0;
                end
            end
            ST_IDLE: begin
                if (col_tick) begin
                    issue   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (col_tick) ovr_d = 1'b1;
                if (credit) begin
                    issue = 1'b1;
                    if (led_q == LED_LAST) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (col_tick) ovr_d = 1'b1;
                if (cnt_q == '0 && !v1_q && !v2_q) begin
                    state_d = ST_IDLE;
                    col_d   = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
                end
            end
            default: state_d = ST_SYNC;
        endcase
        if (issue) led_d = led_q + LW'(1);
        // A simultaneous col_tick survives the abort and restarts column 0.
        if (abort) begin
            issue   = 1'b0;
            state_d = col_tick ? ST_FETCH : ST_IDLE;
            col_d   = '0;
            led_d   = '0;
            ovr_d   = 1'b0;
        end
    end

    always_comb begin
        v1_d     = issue;
        s1_sop_d = issue && (led_q == '0);
        s1_eop_d = issue && (led_q == LED_LAST);
        v2_d     = v1_q && !abort;
        s2_sop_d = s1_sop_q;
        s2_eop_d = s1_eop_q;
    end

    always_comb begin
        push        = v2_q && !abort;
        pop         = (cnt_q != '0) && pix_ready;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        fifo_data_d = fifo_data_q;
        fifo_sop_d  = fifo_sop_q;
        fifo_eop_d  = fifo_eop_q;
        if (abort) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                fifo_data_d[wr_ptr_q] = q;
                fifo_sop_d[wr_ptr_q]  = s2_sop_q;
                fifo_eop_d[wr_ptr_q]  = s2_eop_q;
                wr_ptr_d              = ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d = cnt_q + NW'(push) - NW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_SYNC;
            col_q    <= '0;
            led_q    <= '0;
            ovr_q    <= 1'b0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            s1_sop_q <= 1'b0;
            s1_eop_q <= 1'b0;
            s2_sop_q <= 1'b0;
            s2_eop_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            led_q    <= led_d;
            ovr_q    <= ovr_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            s1_sop_q <= s1_sop_d;
            s1_eop_q <= s1_eop_d;
            s2_sop_q <= s2_sop_d;
            s2_eop_q <= s2_eop_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
        fifo_sop_q  <= fifo_sop_d;
        fifo_eop_q  <= fifo_eop_d;
    end

    always_comb begin
        pix_valid = (cnt_q != '0);
        pix_data  = fifo_data_q[rd_ptr_q];
        pix_sop   = pix_valid && fifo_sop_q[rd_ptr_q];
        pix_eop   = pix_valid && fifo_eop_q[rd_ptr_q];
        col_num   = col_q;
        overrun   = ovr_q;
    end

endmodule

// File: tb/tb_pov_column_reader.sv
// Bench for pov_column_reader: RAM model plus a pixel-stream scoreboard.
module tb_pov_column_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        index_pulse;
    logic        col_tick;
    logic [13:0] rdaddress;
    logic [23:0] q;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sop;
    logic        pix_eop;
    logic [7:0]  col_num;
    logic        overrun;

    always #5 clk = ~clk;

    pov_column_reader #(
        .DAT_WIDTH(24), .ADDR_WIDTH(14), .LEDS_PER_COL(64),
        .NUM_COLS(256), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .index_pulse(index_pulse),
        .col_tick(col_tick), .rdaddress(rdaddress), .q(q),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sop(pix_sop), .pix_eop(pix_eop), .col_num(col_num),
        .overrun(overrun)
    );

    // Frame RAM content: every word carries its own address.
    function automatic logic [23:0] ram_word(input logic [13:0] a);
        return {a[9:0] ^ 10'h2A5, a};
    endfunction

    function automatic logic [13:0] addr_of(input int col, input int i);
`ifdef POV_RD_MIRROR_EN
        return 14'((255 - col) * 64 + i);
`else
        return 14'(col * 64 + i);
`endif
    endfunction

    logic [23:0] q_p1, q_r;
    always @(posedge clk) begin
        q_p1 <= ram_word(rdaddress);
        q_r  <= q_p1;
    end
    assign q = q_r;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit stall_mode = 1'b0;
    logic [25:0] exp_q[$];
    logic [23:0] last_data;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        pix_ready = stall_mode ? (cyc % 3 == 0) : 1'b1;
    endtask

    task automatic expect_col(input int col);
        for (int i = 0; i < 64; i++) begin
            logic s, e;
            s = (i == 0);
            e = (i == 63);
            exp_q.push_back({s, e, ram_word(addr_of(col, i))});
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            step();
            n++;
        end
        if (n >= 1000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: left=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) step();
    endtask

    task automatic run_col(input int col);
        expect_col(col);
        col_tick = 1'b1;
        step();
        col_tick = 1'b0;
        wait_drain();
    endtask

    // Stream checker: every accepted pixel, stall stability, no stray valids.
    logic [25:0] prev;
    bit          prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall)
                chk("stall_stable", {pix_valid, pix_sop, pix_eop, pix_data},
                    {1'b1, prev});
            if (exp_q.size() == 0)
                chk("unexpected_valid", pix_valid, 0);
            else if (pix_valid && pix_ready) begin
                chk("pixel", {pix_sop, pix_eop, pix_data}, exp_q.pop_front());
                last_data = pix_data;
            end
            prev_stall = pix_valid && !pix_ready && !index_pulse;
            prev       = {pix_sop, pix_eop, pix_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n       = 1'b0;
        index_pulse = 1'b0;
        col_tick    = 1'b0;
        pix_ready   = 1'b1;
        repeat (3) step();
        chk("rst_valid", pix_valid, 0);
        chk("rst_sop", pix_sop, 0);
        chk("rst_eop", pix_eop, 0);
        chk("rst_addr", rdaddress, 0);
        chk("rst_col", col_num, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        step();

        col_tick = 1'b1;
        step();
        col_tick = 1'b0;
        repeat (6) step();
        chk("sync_ignores_tick", pix_valid, 0);

        index_pulse = 1'b1;
        step();
        index_pulse = 1'b0;
        step();

        expect_col(0);
        col_tick = 1'b1;
        step();
        col_tick = 1'b0;
        lat = 1;
        while (!pix_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("first_latency", lat, 3);
`ifdef POV_RD_MIRROR_EN
        chk("first_data", pix_data, 24'h597FC0);
`else
        chk("first_data", pix_data, 24'hA94000);
`endif
        chk("first_sop", pix_sop, 1);
        wait_drain();
        chk("col_after_0", col_num, 1);

        stall_mode = 1'b1;
        run_col(1);
        stall_mode = 1'b0;
        chk("col_after_stall", col_num, 2);
        for (int c = 2; c < 5; c++) run_col(c);

        expect_col(5);
        col_tick = 1'b1;
        step();
        col_tick = 1'b0;
        repeat (12) step();
        col_tick = 1'b1;
        step();
        col_tick = 1'b0;
        step();
        chk("overrun_set", overrun, 1);
        wait_drain();
        chk("col_after_overrun", col_num, 6);
        chk("overrun_sticky", overrun, 1);

        run_col(6);
        expect_col(7);
        col_tick = 1'b1;
        step();
        col_tick = 1'b0;
        repeat (22) step();
        index_pulse = 1'b1;
        step();
        index_pulse = 1'b0;
        exp_q.delete();
        chk("abort_no_valid", pix_valid, 0);
        chk("abort_overrun_clr", overrun, 0);
        chk("abort_col", col_num, 0);
        repeat (6) step();
        run_col(0);
        chk("col_after_restart", col_num, 1);

        expect_col(1);
        col_tick = 1'b1;
        step();
        col_tick = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        step();
        exp_q.delete();
        rst_n = 1'b1;
        chk("rst_mid_valid", pix_valid, 0);
        chk("rst_mid_col", col_num, 0);
        repeat (6) step();
        index_pulse = 1'b1;
        step();
        index_pulse = 1'b0;
        step();

        for (int c = 0; c < 256; c++) run_col(c);
        chk("col_wrap", col_num, 0);
`ifdef POV_RD_MIRROR_EN
        chk("col255_last", last_data, 24'hA6803F);
`else
        chk("col255_last", last_data, 24'h56BFFF);
`endif

        expect_col(0);
        col_tick = 1'b1;
        step();
        col_tick = 1'b0;
        repeat (20) step();
        index_pulse = 1'b1;
        col_tick    = 1'b1;
        step();
        index_pulse = 1'b0;
        col_tick    = 1'b0;
        exp_q.delete();
        expect_col(0);
        wait_drain();
        chk("idx_tick_overrun", overrun, 0);
        chk("idx_tick_col", col_num, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
